rosc_sel_inv_model: RTL and testbench

- Clocked, synthesizable behavioural model of an enable-gated ring oscillator. The ring is one NAND2 cell (ND2D2BWP30P140 function) followed by STAGES-1 inverter cells (INVD2BWP30P140 function), with an output load inverter.
- Each cell is modelled as one register stage. Propagation advances one stage per CLK edge, so oscillation frequency is deterministic in CLK cycles.
- Used in the VCO section for digital simulation and frequency-monitor verification.
- Includes an edge counter on OUT for period measurement.

---
 rtl/rosc_sel_inv_model.sv | 74 +++++++
 tb/tb_rosc_sel_inv_model.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rosc_sel_inv_model.sv
// rtl/rosc_sel_inv_model.sv - clocked model of an enable-gated NAND/inverter ring oscillator with OUT edge counter
module rosc_sel_inv_model #(
    parameter int STAGES = 101,
    parameter int FB_DLY = 0,
    parameter int CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN_VCO,
    input  logic             CNT_CLR,
    output logic             OUT,
    output logic [CNT_W-1:0] CNT
);

    if (STAGES < 3 || (STAGES % 2) == 0) begin : g_bad_stages
        $error("STAGES must be odd and at least 3");
    end
    if (FB_DLY < 0 || FB_DLY > 15) begin : g_bad_fb
        $error("FB_DLY must be in 0..15");
    end

    logic [STAGES:1] w;
    logic            outp;
    logic            out_prev;

    // Reset leaves the ring in its disabled steady state: odd cells high, even cells low.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 1; i <= STAGES; i++) begin
                w[i] <= ((i % 2) == 1);
            end
        end else begin
            w[1]        <= ~(EN_VCO & outp);
            w[STAGES:2] <= ~w[STAGES-1:1];
        end
    end

    if (FB_DLY == 0) begin : g_fb_direct
        assign outp = w[STAGES];
    end else begin : g_fb_pipe
        logic [FB_DLY-1:0] fb;

        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                fb <= '1;
            end else begin
                fb[0] <= w[STAGES];
                for (int i = 1; i < FB_DLY; i++) begin
                    fb[i] <= fb[i-1];
                end
            end
        end

        assign outp = fb[FB_DLY-1];
    end

    assign OUT = ~outp;

    // Clear wins over a coincident rising-edge increment.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            out_prev <= 1'b0;
            CNT      <= '0;
        end else begin
            out_prev <= OUT;
            if (CNT_CLR) begin
                CNT <= '0;
            end else if (!out_prev && OUT) begin
                CNT <= CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rosc_sel_inv_model.sv
// tb/tb_rosc_sel_inv_model.sv - self-checking bench for rosc_sel_inv_model across three parameter sets
module tb_rosc_sel_inv_model;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        EN_VCO;
    logic        CNT_CLR;
    logic        out0, out1, out2;
    logic [15:0] cnt0, cnt2;
    logic [3:0]  cnt1;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    rosc_sel_inv_model #(.STAGES(101), .FB_DLY(0), .CNT_W(16)) dut0 (
        .CLK(CLK), .RSTN(RSTN), .EN_VCO(EN_VCO), .CNT_CLR(CNT_CLR), .OUT(out0), .CNT(cnt0));
    rosc_sel_inv_model #(.STAGES(3), .FB_DLY(0), .CNT_W(4)) dut1 (
        .CLK(CLK), .RSTN(RSTN), .EN_VCO(EN_VCO), .CNT_CLR(CNT_CLR), .OUT(out1), .CNT(cnt1));
    rosc_sel_inv_model #(.STAGES(5), .FB_DLY(3), .CNT_W(16)) dut2 (
        .CLK(CLK), .RSTN(RSTN), .EN_VCO(EN_VCO), .CNT_CLR(CNT_CLR), .OUT(out2), .CNT(cnt2));

    // Reference: seen from the edges, the ring is a plain delay line of STAGES+FB_DLY
    // cycles whose input is EN & ~OUT, and OUT is the far end of that line.
    bit dl [3][0:127];
    int len_m [3] = '{101, 3, 8};
    int wd_m  [3] = '{16, 4, 16};
    int cnt_m [3];
    bit prev_m[3];

    function automatic bit mout(input int i);
        return dl[i][len_m[i]-1];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 128; j++) dl[i][j] = 1'b0;
            cnt_m[i]  = 0;
            prev_m[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit en, input bit clr);
        bit o;
        for (int i = 0; i < 3; i++) begin
            o = mout(i);
            if (clr) cnt_m[i] = 0;
            else if (!prev_m[i] && o) cnt_m[i] = (cnt_m[i] + 1) % (1 << wd_m[i]);
            prev_m[i] = o;
            for (int j = len_m[i] - 1; j > 0; j--) dl[i][j] = dl[i][j-1];
            dl[i][0] = en & ~o;
        end
    endtask

    function automatic logic dut_out(input int i);
        case (i)
            0:       return out0;
            1:       return out1;
            default: return out2;
        endcase
    endfunction

    function automatic logic [31:0] dut_cnt(input int i);
        case (i)
            0:       return {16'b0, cnt0};
            1:       return {28'b0, cnt1};
            default: return {16'b0, cnt2};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_out%0d", tag, i), {31'b0, dut_out(i)}, {31'b0, mout(i)});
            check($sformatf("%s_cnt%0d", tag, i), dut_cnt(i), cnt_m[i]);
        end
    endtask

    task automatic tick(input logic en, input logic clr);
        EN_VCO  = en;
        CNT_CLR = clr;
        @(posedge CLK);
        model_step(en, clr);
        #1;
        compare_model("model");
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RSTN = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async_rst_out%0d", i), {31'b0, dut_out(i)}, 32'd0);
            check($sformatf("async_rst_cnt%0d", i), dut_cnt(i), 32'd0);
        end
        model_reset();
        #1;
        RSTN = 1'b1;
    endtask

    typedef struct {
        logic en;
        logic clr;
        logic exp_out;
        int   exp_cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        // STAGES=3 from steady state: enable for 10 edges, drop EN while OUT=1, then clear.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 2};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 2};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 0};

        RSTN    = 1'b0;
        EN_VCO  = 1'b0;
        CNT_CLR = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_out%0d", i), {31'b0, dut_out(i)}, 32'd0);
            check($sformatf("reset_cnt%0d", i), dut_cnt(i), 32'd0);
        end
        RSTN = 1'b1;

        for (int c = 0; c < 300; c++) tick(1'b0, 1'b0);

        for (int v = 0; v < 14; v++) begin
            tick(tbl[v].en, tbl[v].clr);
            check($sformatf("tbl%0d_out", v), {31'b0, out1}, {31'b0, tbl[v].exp_out});
            check($sformatf("tbl%0d_cnt", v), {28'b0, cnt1}, tbl[v].exp_cnt);
        end

        // 17 rises on the 3-stage ring wrap the 4-bit counter; then clear on a detect edge.
        do_reset();
        for (int e = 1; e <= 106; e++) begin
            tick(1'b1, e == 106);
            if (e == 7)   check("fb3_pre_rise", {31'b0, out2}, 32'd0);
            if (e == 8)   check("fb3_rise",     {31'b0, out2}, 32'd1);
            if (e == 15)  check("fb3_high_end", {31'b0, out2}, 32'd1);
            if (e == 16)  check("fb3_fall",     {31'b0, out2}, 32'd0);
            if (e == 100) check("wrap17_cnt",   {28'b0, cnt1}, 32'd1);
            if (e == 106) check("clr_on_rise",  {28'b0, cnt1}, 32'd0);
        end

        do_reset();
        for (int e = 1; e <= 910; e++) begin
            tick(1'b1, 1'b0);
            if (e == 100) check("def_pre_rise", {31'b0, out0}, 32'd0);
            if (e == 101) check("def_rise",     {31'b0, out0}, 32'd1);
            if (e == 201) check("def_high_end", {31'b0, out0}, 32'd1);
            if (e == 202) check("def_fall",     {31'b0, out0}, 32'd0);
            if (e == 909) check("def_cnt4",     {16'b0, cnt0}, 32'd4);
            if (e == 910) check("def_cnt5",     {16'b0, cnt0}, 32'd5);
        end
        for (int e = 0; e < 150; e++) tick(1'b1, 1'b0);

        // Asynchronous reset mid-period, then the enable latency must restart.
        do_reset();
        for (int e = 1; e <= 3; e++) begin
            tick(1'b1, 1'b0);
            check($sformatf("post_rst_e%0d", e), {31'b0, out1}, (e == 3) ? 32'd1 : 32'd0);
        end

        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            tick(($urandom_range(0, 39) == 0) ? ~EN_VCO : EN_VCO, $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
